// File: rtl/frost_round_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frost_round_sync_ctrl
// Purpose  : Multi-round synchronisation barrier for the FROST DKG/signing
//            fabric. Collects per-node arrival strobes for each protocol
//            round and releases the round once QUORUM of NUM_NODES nodes
//            have arrived. It steps a round index through NUM_ROUNDS rounds.
//            An optional per-round timeout reports the nodes that never
//            arrived (stragglers).
// Ports    : clk, rst_n               clock, asynchronous active-low reset
//            start_i, abort_i         run control from the coordinator
//            node_arrive_i            per-node arrival strobe/level
//            round_idx_o              current round (0-based)
//            busy_o                   high while collecting or releasing
//            release_o                one-cycle "round complete" pulse
//            arrived_mask_o           sticky arrival set of current round
//            protocol_done_o          all rounds released
//            timeout_err_o            round timed out
//            straggler_mask_o         nodes missing at timeout
//            wait_cycles_o            saturating cycles spent in this round
//            max_wait_cycles_o        longest completed-round wait
// Options  : define FROST_SYNC_STATS_EN to build the max_wait_cycles_o
//            statistics register. Without the macro, the output is tied to 0.
// Limits   : CNT_W <= 32 for the timeout comparison; NUM_ROUNDS <= 256.
// Revision : 1.0  initial release
// ============================================================================
module frost_round_sync_ctrl #(
  parameter int NUM_NODES      = 4,
  parameter int QUORUM         = 4,
  parameter int NUM_ROUNDS     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_NODES-1:0] node_arrive_i,
  output logic [7:0]           round_idx_o,
  output logic                 busy_o,
  output logic                 release_o,
  output logic [NUM_NODES-1:0] arrived_mask_o,
  output logic                 protocol_done_o,
  output logic                 timeout_err_o,
  output logic [NUM_NODES-1:0] straggler_mask_o,
  output logic [CNT_W-1:0]     wait_cycles_o,
  output logic [CNT_W-1:0]     max_wait_cycles_o
);

  localparam int                 c_pop_w      = $clog2(NUM_NODES + 1);
  localparam logic [c_pop_w-1:0] c_quorum     = c_pop_w'(QUORUM);
  localparam logic [7:0]         c_last_round = 8'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e               state_q,   state_d;
  logic [7:0]           round_q,   round_d;
  logic [NUM_NODES-1:0] arrived_q, arrived_d;
  logic [NUM_NODES-1:0] strag_q,   strag_d;
  logic [CNT_W-1:0]     wait_q,    wait_d;

  logic [NUM_NODES-1:0] w_union;
  logic [c_pop_w-1:0]   w_pop;
  logic                 w_quorum;
  logic                 w_timeout_hit;
  logic [CNT_W-1:0]     w_wait_inc;

  // Arrivals seen in the current cycle count toward the quorum immediately.
  // This gives the one-cycle arrival-to-release latency.
  assign w_union = arrived_q | node_arrive_i;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      w_pop = w_pop + c_pop_w'(w_union[i]);
    end
  end

  assign w_quorum   = (w_pop >= c_quorum);
  assign w_wait_inc = (&wait_q) ? wait_q : wait_q + CNT_W'(1);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end else begin : g_timeout
      assign w_timeout_hit = (32'(wait_q) == 32'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      arrived_q <= '0;
      strag_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      arrived_q <= arrived_d;
      strag_q   <= strag_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    round_d         = round_q;
    arrived_d       = arrived_q;
    strag_d         = strag_q;
    wait_d          = wait_q;
    busy_o          = 1'b0;
    release_o       = 1'b0;
    protocol_done_o = 1'b0;
    timeout_err_o   = 1'b0;

    unique case (state_q)
      ST_COLLECT: busy_o = 1'b1;
      ST_RELEASE: begin
        busy_o    = 1'b1;
        release_o = 1'b1;
      end
      ST_DONE:    protocol_done_o = 1'b1;
      ST_TIMEOUT: timeout_err_o   = 1'b1;
      default:    ;
    endcase

    if (abort_i) begin
      state_d   = ST_IDLE;
      round_d   = '0;
      arrived_d = '0;
      strag_d   = '0;
      wait_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          // A fresh run clears every trace of the previous run.
          if (start_i) begin
            state_d   = ST_COLLECT;
            round_d   = '0;
            arrived_d = '0;
            strag_d   = '0;
            wait_d    = '0;
          end
        end
        ST_COLLECT: begin
          arrived_d = w_union;
          wait_d    = w_wait_inc;
          // A quorum wins over a timeout that lands in the same cycle.
          if (w_quorum) begin
            state_d = ST_RELEASE;
          end else if (w_timeout_hit) begin
            state_d = ST_TIMEOUT;
            strag_d = ~w_union;
          end
        end
        ST_RELEASE: begin
          if (round_q == c_last_round) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_COLLECT;
            round_d   = round_q + 8'd1;
            arrived_d = '0;
            wait_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign round_idx_o      = round_q;
  assign arrived_mask_o   = arrived_q;
  assign straggler_mask_o = strag_q;
  assign wait_cycles_o    = wait_q;

`ifdef FROST_SYNC_STATS_EN
  // A round's wait includes its release cycle, hence the saturating +1.
  // Abort leaves the statistic untouched; only rst_n clears it.
  logic [CNT_W-1:0] max_wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_wait_q <= '0;
    end else if (state_q == ST_RELEASE && w_wait_inc > max_wait_q) begin
      max_wait_q <= w_wait_inc;
    end
  end

  assign max_wait_cycles_o = max_wait_q;
`else
  assign max_wait_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frost_round_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
module tb_frost_round_sync_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] arr   = 4'h0;

  always #5 clk = ~clk;

  // Instance A: N=4 Q=4 R=2 T=16 CNT_W=16
  logic [7:0]  a_round; logic a_busy, a_rel, a_done, a_err;
  logic [3:0]  a_mask, a_strag;
  logic [15:0] a_wait, a_max;
  // Instance B: N=4 Q=2 R=3 T=8 CNT_W=3 (counter saturates at 7)
  logic [7:0]  b_round; logic b_busy, b_rel, b_done, b_err;
  logic [3:0]  b_mask, b_strag;
  logic [2:0]  b_wait, b_max;

  frost_round_sync_ctrl #(.NUM_NODES(4), .QUORUM(4), .NUM_ROUNDS(2),
                          .TIMEOUT_CYCLES(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .node_arrive_i(arr), .round_idx_o(a_round), .busy_o(a_busy),
    .release_o(a_rel), .arrived_mask_o(a_mask), .protocol_done_o(a_done),
    .timeout_err_o(a_err), .straggler_mask_o(a_strag),
    .wait_cycles_o(a_wait), .max_wait_cycles_o(a_max));

  frost_round_sync_ctrl #(.NUM_NODES(4), .QUORUM(2), .NUM_ROUNDS(3),
                          .TIMEOUT_CYCLES(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .node_arrive_i(arr), .round_idx_o(b_round), .busy_o(b_busy),
    .release_o(b_rel), .arrived_mask_o(b_mask), .protocol_done_o(b_done),
    .timeout_err_o(b_err), .straggler_mask_o(b_strag),
    .wait_cycles_o(b_wait), .max_wait_cycles_o(b_max));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int S_IDLE = 0, S_COL = 1, S_REL = 2, S_DONE = 3, S_TO = 4;
  typedef struct {
    int st; int rnd; int mask; int wt; int strag; int mx;
  } mdl_t;
  mdl_t m[2];

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input int q, input int r,
                                 input int t, input int maxw, input bit s,
                                 input bit a, input int arrv);
    mdl_t n;
    int   u;
    n = c;
    if (c.st == S_REL && sat(c.wt + 1, maxw) > n.mx) n.mx = sat(c.wt + 1, maxw);
    if (a) begin
      n.st = S_IDLE; n.rnd = 0; n.mask = 0; n.wt = 0; n.strag = 0;
      return n;
    end
    case (c.st)
      S_IDLE, S_DONE, S_TO:
        if (s) begin
          n.st = S_COL; n.rnd = 0; n.mask = 0; n.wt = 0; n.strag = 0;
        end
      S_COL: begin
        u      = c.mask | arrv;
        n.mask = u;
        n.wt   = sat(c.wt + 1, maxw);
        if ($countones(u) >= q) n.st = S_REL;
        else if (t != 0 && c.wt == t - 1) begin
          n.st = S_TO; n.strag = (~u) & 15;
        end
      end
      S_REL:
        if (c.rnd == r - 1) n.st = S_DONE;
        else begin
          n.st = S_COL; n.rnd = c.rnd + 1; n.mask = 0; n.wt = 0;
        end
      default: ;
    endcase
    return n;
  endfunction

  function automatic mdl_t mzero(input mdl_t c);
    mdl_t n;
    n = c;
    n.st = S_IDLE; n.rnd = 0; n.mask = 0; n.wt = 0; n.strag = 0; n.mx = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mzero(m[0]);
      m[1] <= mzero(m[1]);
    end else begin
      m[0] <= mstep(m[0], 4, 2, 16, 65535, start, abort, int'(arr));
      m[1] <= mstep(m[1], 2, 3, 8, 7, start, abort, int'(arr));
    end
  end

  task automatic cmp_inst(input string p, input int i, input logic [7:0] rnd,
                          input logic busy, input logic rel, input logic [3:0] mask,
                          input logic done, input logic err, input logic [3:0] strag,
                          input logic [15:0] wt, input logic [15:0] mx);
    int exp_mx;
`ifdef FROST_SYNC_STATS_EN
    exp_mx = m[i].mx;
`else
    exp_mx = 0;
`endif
    chk({p, ".round_idx"},      32'(rnd),   32'(m[i].rnd));
    chk({p, ".busy"},           32'(busy),  32'(m[i].st == S_COL || m[i].st == S_REL));
    chk({p, ".release"},        32'(rel),   32'(m[i].st == S_REL));
    chk({p, ".arrived_mask"},   32'(mask),  32'(m[i].mask));
    chk({p, ".protocol_done"},  32'(done),  32'(m[i].st == S_DONE));
    chk({p, ".timeout_err"},    32'(err),   32'(m[i].st == S_TO));
    chk({p, ".straggler_mask"}, 32'(strag), 32'(m[i].strag));
    chk({p, ".wait_cycles"},    32'(wt),    32'(m[i].wt));
    chk({p, ".max_wait"},       32'(mx),    32'(exp_mx));
  endtask

  always @(negedge clk) begin
    cmp_inst("A", 0, a_round, a_busy, a_rel, a_mask, a_done, a_err, a_strag, a_wait, a_max);
    cmp_inst("B", 1, b_round, b_busy, b_rel, b_mask, b_done, b_err, b_strag,
             16'(b_wait), 16'(b_max));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit s, input bit a, input logic [3:0] v);
    start = s; abort = a; arr = v;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("lit.reset_busy", 32'(a_busy), 32'd0);
    chk("lit.reset_round", 32'(a_round), 32'd0);
    rst_n = 1'b1;

    // Round 0 on A: nodes 0,1,2 then node 3 after a gap.
    drv(1, 0, 4'h0);
    chk("lit.start_busy", 32'(a_busy), 32'd1);
    drv(0, 0, 4'h1);
    drv(0, 0, 4'h2);
    chk("lit.B_release_q2", 32'(b_rel), 32'd1);
    chk("lit.B_mask_q2", 32'(b_mask), 32'h3);
    drv(0, 0, 4'h4);
    chk("lit.B_late_ignored", 32'(b_mask), 32'h0);
    chk("lit.B_round1", 32'(b_round), 32'd1);
    drv(0, 0, 4'h0);
    chk("lit.A_no_early_release", 32'(a_rel), 32'd0);
    drv(0, 0, 4'h8);
    chk("lit.A_release", 32'(a_rel), 32'd1);
    chk("lit.A_final_mask", 32'(a_mask), 32'hF);
    chk("lit.A_round0", 32'(a_round), 32'd0);
    chk("lit.A_wait5", 32'(a_wait), 32'd5);
    drv(0, 0, 4'h0);
    chk("lit.A_round1", 32'(a_round), 32'd1);
    chk("lit.A_mask_cleared", 32'(a_mask), 32'h0);
`ifdef FROST_SYNC_STATS_EN
    chk("lit.A_max6", 32'(a_max), 32'd6);
`endif
    // Round 1: all four together.
    drv(0, 0, 4'hF);
    chk("lit.A_release_r1", 32'(a_rel), 32'd1);
    drv(0, 0, 4'h0);
    chk("lit.A_done", 32'(a_done), 32'd1);
    chk("lit.A_done_round", 32'(a_round), 32'd1);

    // Abort in round 1 COLLECT.
    drv(1, 0, 4'h0);
    drv(0, 0, 4'hF);
    drv(0, 0, 4'h0);
    chk("lit.A_r1_busy", 32'(a_busy), 32'd1);
    drv(0, 1, 4'h0);
    chk("lit.abort_busy", 32'(a_busy), 32'd0);
    chk("lit.abort_round", 32'(a_round), 32'd0);
`ifdef FROST_SYNC_STATS_EN
    chk("lit.abort_keeps_max", 32'(a_max), 32'd6);
`endif

    // Timeout on B: only node 2 arrives.
    drv(1, 0, 4'h0);
    repeat (7) drv(0, 0, 4'h4);
    chk("lit.B_no_timeout_yet", 32'(b_err), 32'd0);
    drv(0, 0, 4'h4);
    chk("lit.B_timeout", 32'(b_err), 32'd1);
    chk("lit.B_stragglers", 32'(b_strag), 32'hB);

    // Quorum on the exact timeout cycle for B; start is ignored by A (COLLECT).
    drv(1, 0, 4'h0);
    chk("lit.B_err_cleared", 32'(b_err), 32'd0);
    repeat (7) drv(0, 0, 4'h0);
    drv(0, 0, 4'h3);
    chk("lit.B_quorum_beats_timeout", 32'(b_rel), 32'd1);
    chk("lit.B_no_err", 32'(b_err), 32'd0);
    chk("lit.B_wait_saturated", 32'(b_wait), 32'd7);
    chk("lit.A_timeout", 32'(a_err), 32'd1);
    chk("lit.A_stragglers", 32'(a_strag), 32'hB);

    // Reset in the middle of a round.
    drv(1, 0, 4'h0);
    drv(0, 0, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("lit.rst_busy", 32'(a_busy), 32'd0);
    chk("lit.rst_mask", 32'(a_mask), 32'h0);
    arr = 4'hF;
    tick();
    chk("lit.rst_no_release", 32'(a_rel), 32'd0);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    repeat (3000) begin
      start = ($urandom % 8) == 0;
      abort = ($urandom % 40) == 0;
      for (int b = 0; b < 4; b++) arr[b] = ($urandom % 6) == 0;
      rst_n = ($urandom % 700) != 0;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
